// File: rtl/spi_master_pkg.sv
// Shared definitions for the Wishbone SPI master: register word indices and engine states.
// Register constants are word indices (byte offset >> 2), matching the adr[4:2] decode.
package spi_master_pkg;

    localparam logic [2:0] REG_STATUS     = 3'd0;
    localparam logic [2:0] REG_ARM        = 3'd1;
    localparam logic [2:0] REG_FROM_SLAVE = 3'd2;
    localparam logic [2:0] REG_TO_SLAVE   = 3'd3;
    localparam logic [2:0] REG_WAIT       = 3'd4;

    typedef enum logic [2:0] {
        ST_READY,
        ST_SS_SETUP,
        ST_SHIFT,
        ST_SS_HOLD,
        ST_FINISHED
    } engine_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI transfer engine: SCK divider, MSB-first shifters and ss_L sequencing for one WID-bit frame.
// A frame, once armed, always runs to completion; only rst aborts it.
module spi_shift_engine
    import spi_master_pkg::*;
#(
    parameter int unsigned WID             = 24,
    parameter bit          POLARITY        = 1'b0,
    parameter bit          PHASE           = 1'b1,
    parameter int unsigned CYCLE_HALF_WAIT = 1,
    parameter int unsigned SS_WAIT         = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           arm,
    input  logic [WID-1:0] to_slave,
    output logic           ready,
    output logic           finished,
    output logic [WID-1:0] from_slave,
    output logic           sck,
    output logic           mosi,
    input  logic           miso,
    output logic           ss_L
);

    localparam int unsigned CNT_MAX = (SS_WAIT > CYCLE_HALF_WAIT) ? SS_WAIT : CYCLE_HALF_WAIT;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned EDGES   = 2 * WID;
    localparam int unsigned EDGE_W  = $clog2(EDGES);

    engine_state_e  state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [WID-1:0] tx_q, tx_d, rx_q, rx_d, from_q, from_d;
    logic sck_q, sck_d, mosi_q, mosi_d, ss_q, ss_d;
    logic ready_q, ready_d, finished_q, finished_d;

    logic [CNT_W-1:0] cnt_lim_c;
    logic cnt_done_c, last_edge_c, shift_edge_c;

    always_comb begin
        cnt_lim_c = CNT_W'(SS_WAIT - 1);
        if (state_q == ST_SHIFT) cnt_lim_c = CNT_W'(CYCLE_HALF_WAIT - 1);
    end

    assign cnt_done_c   = (cnt_q == cnt_lim_c);
    assign last_edge_c  = (edge_q == EDGE_W'(EDGES - 1));
    // Even-numbered edges are leading; PHASE=1 shifts on them, PHASE=0 samples on them.
    assign shift_edge_c = (~edge_q[0]) == PHASE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_READY;
            cnt_q      <= '0;
            edge_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            from_q     <= '0;
            sck_q      <= POLARITY;
            mosi_q     <= 1'b0;
            ss_q       <= 1'b1;
            ready_q    <= 1'b1;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            from_q     <= from_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            ss_q       <= ss_d;
            ready_q    <= ready_d;
            finished_q <= finished_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_READY:    if (arm) state_d = ST_SS_SETUP;
            ST_SS_SETUP: if (cnt_done_c) state_d = ST_SHIFT;
            ST_SHIFT:    if (cnt_done_c && last_edge_c) state_d = ST_SS_HOLD;
            ST_SS_HOLD:  if (cnt_done_c) state_d = ST_FINISHED;
            ST_FINISHED: if (!arm) state_d = ST_READY;
            default:     state_d = ST_READY;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        edge_d     = edge_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        from_d     = from_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        ss_d       = ss_q;
        ready_d    = ready_q;
        finished_d = finished_q;
        case (state_q)
            ST_READY: begin
                if (arm) begin
                    cnt_d   = '0;
                    edge_d  = '0;
                    rx_d    = '0;
                    ss_d    = 1'b0;
                    ready_d = 1'b0;
                    // PHASE=0 presents the MSB before the first edge.
                    if (PHASE) begin
                        tx_d = to_slave;
                    end else begin
                        tx_d   = {to_slave[WID-2:0], 1'b0};
                        mosi_d = to_slave[WID-1];
                    end
                end
            end
            ST_SS_SETUP: cnt_d = cnt_done_c ? '0 : cnt_q + CNT_W'(1);
            ST_SHIFT: begin
                cnt_d = cnt_done_c ? '0 : cnt_q + CNT_W'(1);
                if (cnt_done_c) begin
                    sck_d  = ~sck_q;
                    edge_d = edge_q + EDGE_W'(1);
                    if (shift_edge_c) begin
                        mosi_d = tx_q[WID-1];
                        tx_d   = {tx_q[WID-2:0], 1'b0};
                    end else begin
                        rx_d = {rx_q[WID-2:0], miso};
                    end
                end
            end
            ST_SS_HOLD: begin
                cnt_d = cnt_done_c ? '0 : cnt_q + CNT_W'(1);
                if (cnt_done_c) begin
                    ss_d       = 1'b1;
                    from_d     = rx_q;
                    finished_d = 1'b1;
                end
            end
            ST_FINISHED: begin
                if (!arm) begin
                    finished_d = 1'b0;
                    ready_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ready      = ready_q;
    assign finished   = finished_q;
    assign from_slave = from_q;
    assign sck        = sck_q;
    assign mosi       = mosi_q;
    assign ss_L       = ss_q;

endmodule

// File: rtl/spi_master_wb.sv
// Wishbone classic slave front-end for the SPI engine: address decode, register file
// and the blocking status window that withholds ack until ready or finished.
module spi_master_wb
    import spi_master_pkg::*;
#(
    parameter int unsigned WID             = 24,
    parameter bit          POLARITY        = 1'b0,
    parameter bit          PHASE           = 1'b1,
    parameter int unsigned CYCLE_HALF_WAIT = 1,
    parameter int unsigned SS_WAIT         = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [3:0]  wb_sel,
    input  logic [31:0] wb_adr,
    input  logic [31:0] wb_dat_w,
    output logic [31:0] wb_dat_r,
    output logic        wb_ack,
    output logic        sck,
    output logic        mosi,
    input  logic        miso,
    output logic        ss_L
);

    logic           ack_q, ack_d;
    logic [31:0]    dat_q, dat_d;
    logic           arm_q, arm_d;
    logic [WID-1:0] to_slave_q, to_slave_d;
    logic [WID-1:0] from_slave;
    logic           ready, finished;
    logic           req_c;
    logic [2:0]     idx_c;
    logic           unused_c;

    // Byte lanes and address/data bits outside the decoded window are don't-care.
    assign unused_c = ^{wb_sel, wb_adr, wb_dat_w};

    // A request is new only while ack is low, so a held cycle can never ack twice in a row.
    assign req_c = wb_cyc & wb_stb & ~ack_q;
    assign idx_c = wb_adr[4:2];

    always_comb begin
        ack_d      = 1'b0;
        dat_d      = '0;
        arm_d      = arm_q;
        to_slave_d = to_slave_q;
        if (req_c && ((idx_c != REG_WAIT) || ready || finished)) begin
            ack_d = 1'b1;
            if (wb_we) begin
                if (idx_c == REG_ARM)      arm_d      = wb_dat_w[0];
                if (idx_c == REG_TO_SLAVE) to_slave_d = wb_dat_w[WID-1:0];
            end
            case (idx_c)
                REG_STATUS, REG_WAIT: dat_d = {30'b0, finished, ready};
                REG_ARM:              dat_d = {31'b0, arm_q};
                REG_FROM_SLAVE:       dat_d = 32'(from_slave);
                REG_TO_SLAVE:         dat_d = 32'(to_slave_q);
                default:              dat_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            arm_q      <= 1'b0;
            to_slave_q <= '0;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            arm_q      <= arm_d;
            to_slave_q <= to_slave_d;
        end
    end

    assign wb_ack   = ack_q;
    assign wb_dat_r = dat_q;

    spi_shift_engine #(
        .WID             (WID),
        .POLARITY        (POLARITY),
        .PHASE           (PHASE),
        .CYCLE_HALF_WAIT (CYCLE_HALF_WAIT),
        .SS_WAIT         (SS_WAIT)
    ) u_engine (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm_q),
        .to_slave   (to_slave_q),
        .ready      (ready),
        .finished   (finished),
        .from_slave (from_slave),
        .sck        (sck),
        .mosi       (mosi),
        .miso       (miso),
        .ss_L       (ss_L)
    );

endmodule
